noise_window_detector: RTL

Parametrised successor to the single-threshold noise detector in the QRS front end.
- Counts detail-coefficient samples whose magnitude exceeds Tn inside a fixed sample window.
- Asserts Select when the per-window count reaches a programmable threshold.
- Deasserts Select only after a quiet hold-off, so Select does not chatter.
- Sits between the wavelet decomposition stage and the QRS decision logic, gating peak detection during noisy segments.

---
 rtl/noise_window_detector.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/noise_window_detector.sv
// noise_window_detector
// Counts detail-coefficient samples whose magnitude exceeds Tn inside fixed
// windows of WIN_LEN valid samples. Select rises when a window holds at least
// CNT_TH exceedances. It falls only after HOLD_LEN consecutive quiet samples.
// Optional build macro NOISE_WINDOW_EVCNT_EN adds the noise_events counter,
// which counts CLEAN->NOISY entries and saturates.
//
// state | meaning
// ------+------------------------------------------------------------------
// CLEAN | no noise; Select=0
// NOISY | last closed window qualified as noisy; Select=1
// HOLD  | window went quiet, waiting HOLD_LEN quiet samples; Select=1
module noise_window_detector #(
    parameter int DATA_W   = 16,
    parameter int WIN_LEN  = 32,
    parameter int CNT_TH   = 4,
    parameter int HOLD_LEN = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid,
    input  logic [DATA_W-1:0]              D1,
    input  logic [DATA_W-1:0]              Tn,
    output logic                           Select,
    output logic [$clog2(WIN_LEN+1)-1:0]   exceed_cnt,
    output logic                           win_done
`ifdef NOISE_WINDOW_EVCNT_EN
    ,
    output logic [15:0]                    noise_events
`endif
);

    localparam int CW = $clog2(WIN_LEN + 1);
    localparam int WW = $clog2(WIN_LEN);
    localparam int HW = $clog2(HOLD_LEN + 1);

    localparam logic [WW-1:0]     WIN_LAST  = WW'(WIN_LEN - 1);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_LEN - 1);
    localparam logic [CW-1:0]     CNT_TH_C  = CW'(CNT_TH);
    localparam logic [DATA_W-1:0] MAG_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ONE_D     = {{(DATA_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        CLEAN = 2'd0,
        NOISY = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WW-1:0]   win_cnt;
    logic [HW-1:0]   hold_cnt, hold_nxt;
    logic [DATA_W-1:0] mag;
    logic            ex;
    logic            win_close;
    logic [CW-1:0]   final_cnt;
    logic            qualify;

    // Absolute value of D1; the most-negative code saturates so mag fits DATA_W
    always_comb begin
        if (!D1[DATA_W-1])
            mag = D1;
        else if (D1 == MOST_NEG)
            mag = MAG_MAX;
        else
            mag = (~D1) + ONE_D;
    end

    assign ex        = valid && (mag > Tn);
    assign win_close = valid && (win_cnt == WIN_LAST);
    assign final_cnt = exceed_cnt + {{(CW-1){1'b0}}, ex};
    assign qualify   = (final_cnt >= CNT_TH_C);

    // Window position and exceedance count; win_done pulses after each close
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_cnt    <= '0;
            exceed_cnt <= '0;
            win_done   <= 1'b0;
        end else begin
            win_done <= 1'b0;
            if (valid) begin
                if (win_close) begin
                    win_cnt    <= '0;
                    exceed_cnt <= '0;
                    win_done   <= 1'b1;
                end else begin
                    win_cnt    <= win_cnt + WW'(1);
                    exceed_cnt <= final_cnt;
                end
            end
        end
    end

    // Next-state and hold-off counter; a qualifying close beats hold expiry
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        if (valid) begin
            case (state)
                CLEAN: begin
                    if (win_close && qualify)
                        state_nxt = NOISY;
                end
                NOISY: begin
                    if (win_close && !qualify) begin
                        state_nxt = HOLD;
                        hold_nxt  = '0;
                    end
                end
                HOLD: begin
                    if (win_close && qualify) begin
                        state_nxt = NOISY;
                        hold_nxt  = '0;
                    end else if (ex) begin
                        hold_nxt = '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nxt = CLEAN;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state_nxt = CLEAN;
                    hold_nxt  = '0;
                end
            endcase
        end
    end

    // State register; Select is registered straight from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= CLEAN;
            hold_cnt <= '0;
            Select   <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            Select   <= (state_nxt != CLEAN);
        end
    end

`ifdef NOISE_WINDOW_EVCNT_EN
    // Count fresh noise episodes only (CLEAN->NOISY), saturating at all ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            noise_events <= '0;
        else if ((state == CLEAN) && (state_nxt == NOISY) && (noise_events != 16'hFFFF))
            noise_events <= noise_events + 16'd1;
    end
`endif

endmodule
